// File: rtl/mem_arbiter_ctrl_if.sv
// mem_arbiter_ctrl_if: bundles the two requester ports and the byte-wide RAM
// port of the memory arbiter. The arbiter uses the slave modport; the master
// modport is the system side (IF unit, MEM stage and the RAM itself).
interface mem_arbiter_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_data;
  logic [3:0]        mem_req_type;
  logic              mem_busy;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, mem_req, mem_req_addr, mem_req_data, mem_req_type, ram_din,
    output if_done, if_data, mem_busy, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_req_addr, mem_req_data, mem_req_type, ram_din,
    input  if_done, if_data, mem_busy, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates instruction fetch and MEM-stage accesses onto a
// single byte-wide RAM port, splitting each access into 1/2/4 byte cycles and
// returning extended read data with a one-cycle done pulse.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN -- when defined, simultaneous
// requests alternate using a last_owner flop; otherwise MEM always beats IF.
module mem_arbiter_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_LAST = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Request type decode: {valid, store, sign_extend, size(N-1)}
  function automatic logic [4:0] decode_type(input logic [3:0] t);
    case (t)
      4'd1:    decode_type = 5'b1_0_1_00;  // LB
      4'd2:    decode_type = 5'b1_0_1_01;  // LH
      4'd3:    decode_type = 5'b1_0_0_11;  // LW
      4'd4:    decode_type = 5'b1_0_0_01;  // LHU
      4'd5:    decode_type = 5'b1_0_0_00;  // LBU
      4'd6:    decode_type = 5'b1_1_0_00;  // SB
      4'd7:    decode_type = 5'b1_1_0_01;  // SH
      4'd8:    decode_type = 5'b1_1_0_11;  // SW
      default: decode_type = 5'b0_0_0_00;
    endcase
  endfunction

  // Sign/zero extension of an assembled load to 32 bits
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic sext);
    case (size)
      2'd0:    extend = {{24{sext & raw[7]}}, raw[7:0]};
      2'd1:    extend = {{16{sext & raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  state_t            state_r, state_s;
  logic [1:0]        cnt_r, cnt_s;
  logic [1:0]        size_r, size_s;
  logic              sext_r, sext_s;
  logic              owner_r, owner_s;
  logic [31:0]       data_r, data_s;
  logic [31:0]       acc_r, acc_s;
  logic              if_done_r, if_done_s;
  logic [31:0]       if_data_r, if_data_s;
  logic              mem_busy_r, mem_busy_s;
  logic              mem_done_r, mem_done_s;
  logic [31:0]       mem_rdata_r, mem_rdata_s;
  logic [7:0]        ram_dout_r, ram_dout_s;
  logic [ADDR_W-1:0] ram_a_r, ram_a_s;
  logic              ram_wr_r, ram_wr_s;

  logic [4:0]        mem_dec_s;
  logic              mem_valid_s;
  logic              grant_mem_s;
  logic              grant_if_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_owner_r;
`endif

  // Arbitration: decide which requester would be granted if the FSM is idle
  always_comb begin
    mem_dec_s   = decode_type(bus.mem_req_type);
    mem_valid_s = bus.mem_req & mem_dec_s[4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (mem_valid_s && bus.if_req) begin
      grant_mem_s = (last_owner_r == OWN_IF);
    end else begin
      grant_mem_s = mem_valid_s;
    end
`else
    grant_mem_s = mem_valid_s;
`endif
    grant_if_s = bus.if_req & ~grant_mem_s;
  end

  // Next-state and next-output logic of the access sequencer
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    size_s      = size_r;
    sext_s      = sext_r;
    owner_s     = owner_r;
    data_s      = data_r;
    acc_s       = acc_r;
    if_done_s   = 1'b0;
    if_data_s   = if_data_r;
    mem_done_s  = 1'b0;
    mem_rdata_s = mem_rdata_r;
    ram_dout_s  = ram_dout_r;
    ram_a_s     = ram_a_r;
    ram_wr_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (grant_mem_s) begin
          owner_s = OWN_MEM;
          size_s  = mem_dec_s[1:0];
          sext_s  = mem_dec_s[2];
          data_s  = bus.mem_req_data;
          ram_a_s = bus.mem_req_addr;
          cnt_s   = 2'd0;
          acc_s   = 32'h0000_0000;
          if (mem_dec_s[3]) begin
            state_s    = ST_WR;
            ram_dout_s = bus.mem_req_data[7:0];
            ram_wr_s   = 1'b1;
          end else begin
            state_s    = ST_RD;
          end
        end else if (grant_if_s) begin
          owner_s = OWN_IF;
          size_s  = 2'd3;
          sext_s  = 1'b0;
          ram_a_s = bus.if_addr;
          cnt_s   = 2'd0;
          acc_s   = 32'h0000_0000;
          state_s = ST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RD: begin
        // Byte cnt-1 arrives now, one cycle behind its address
        if (cnt_r != 2'd0) begin
          acc_s[{cnt_r - 2'd1, 3'b000} +: 8] = bus.ram_din;
        end else begin
          acc_s = acc_r;
        end
        if (cnt_r == size_r) begin
          state_s = ST_RD_LAST;
        end else begin
          cnt_s   = cnt_r + 2'd1;
          ram_a_s = ram_a_r + ADDR_ONE;
        end
      end

      ST_RD_LAST: begin
        acc_s[{cnt_r, 3'b000} +: 8] = bus.ram_din;
        state_s = ST_DONE;
        if (owner_r == OWN_IF) begin
          if_done_s = 1'b1;
          if_data_s = acc_s;
        end else begin
          mem_done_s  = 1'b1;
          mem_rdata_s = extend(acc_s, size_r, sext_r);
        end
      end

      ST_WR: begin
        if (cnt_r == size_r) begin
          state_s     = ST_DONE;
          mem_done_s  = 1'b1;
          mem_rdata_s = 32'h0000_0000;
        end else begin
          cnt_s      = cnt_r + 2'd1;
          ram_a_s    = ram_a_r + ADDR_ONE;
          ram_dout_s = data_r[{cnt_s, 3'b000} +: 8];
          ram_wr_s   = 1'b1;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    mem_busy_s = (state_s != ST_IDLE);
  end

  // State, latched transaction context and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      size_r      <= 2'd0;
      sext_r      <= 1'b0;
      owner_r     <= OWN_IF;
      data_r      <= 32'h0000_0000;
      acc_r       <= 32'h0000_0000;
      if_done_r   <= 1'b0;
      if_data_r   <= 32'h0000_0000;
      mem_busy_r  <= 1'b0;
      mem_done_r  <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
      ram_dout_r  <= 8'h00;
      ram_a_r     <= {ADDR_W{1'b0}};
      ram_wr_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      size_r      <= size_s;
      sext_r      <= sext_s;
      owner_r     <= owner_s;
      data_r      <= data_s;
      acc_r       <= acc_s;
      if_done_r   <= if_done_s;
      if_data_r   <= if_data_s;
      mem_busy_r  <= mem_busy_s;
      mem_done_r  <= mem_done_s;
      mem_rdata_r <= mem_rdata_s;
      ram_dout_r  <= ram_dout_s;
      ram_a_r     <= ram_a_s;
      ram_wr_r    <= ram_wr_s;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember who won the most recent grant so a tie goes to the other side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_r <= OWN_IF;
    end else if ((state_r == ST_IDLE) && (grant_mem_s || grant_if_s)) begin
      last_owner_r <= grant_mem_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`endif

  assign bus.if_done   = if_done_r;
  assign bus.if_data   = if_data_r;
  assign bus.mem_busy  = mem_busy_r;
  assign bus.mem_done  = mem_done_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.ram_dout  = ram_dout_r;
  assign bus.ram_a     = ram_a_r;
  assign bus.ram_wr    = ram_wr_r;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: directed and randomized checks of mem_arbiter_ctrl
// against a byte-array memory model and a table of per-type latencies.
module tb_mem_arbiter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  mem_arbiter_ctrl_if #(.ADDR_W(32)) bus ();

  mem_arbiter_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM contents seen by the DUT, and the expected contents
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Synchronous RAM: read data appears the cycle after its address
  always @(posedge clk) begin
    if (bus.ram_wr === 1'b1) ram[bus.ram_a] = bus.ram_dout;
    bus.ram_din <= ram_rd(bus.ram_a);
  end

  // Expected load value from the reference memory (typ 3 also covers IF)
  function automatic logic [31:0] ref_load(input logic [3:0] typ, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_rd(a);
    b1 = ref_rd(a + 32'd1);
    b2 = ref_rd(a + 32'd2);
    b3 = ref_rd(a + 32'd3);
    case (typ)
      4'd1:    return 32'($signed(b0));
      4'd2:    return 32'($signed({b1, b0}));
      4'd4:    return {16'h0000, b1, b0};
      4'd5:    return {24'h000000, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic int nbytes(input logic own_mem, input logic [3:0] typ);
    if (!own_mem) return 4;
    case (typ)
      4'd1, 4'd5, 4'd6: return 1;
      4'd2, 4'd4, 4'd7: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic int latency(input logic own_mem, input logic [3:0] typ);
    if (!own_mem) return 6;
    case (typ)
      4'd1, 4'd5: return 3;
      4'd2, 4'd4: return 4;
      4'd3:       return 6;
      4'd6:       return 2;
      4'd7:       return 3;
      default:    return 5;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  // One transaction from a single requester; starts and ends just after a negedge
  task automatic issue(input logic own_mem, input logic [3:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] got);
    int n, nb, lat;
    logic is_st, seen, stray, busy_ok;
    logic [31:0] exp;
    is_st = own_mem && (typ >= 4'd6);
    nb    = nbytes(own_mem, typ);
    lat   = latency(own_mem, typ);
    exp   = is_st ? 32'h0 : ref_load(own_mem ? typ : 4'd3, addr);
    if (own_mem) begin
      bus.mem_req = 1'b1; bus.mem_req_type = typ;
      bus.mem_req_addr = addr; bus.mem_req_data = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    n = 0; seen = 1'b0; stray = 1'b0; busy_ok = 1'b1; got = 32'h0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        // Inputs may wander once granted; the latched copies must be used
        bus.mem_req_addr = $urandom; bus.mem_req_data = $urandom;
        bus.mem_req_type = 4'($urandom_range(0, 15)); bus.if_addr = $urandom;
      end
      if (n <= nb) begin
        check("ram_a", bus.ram_a, addr + 32'(n - 1));
        check("ram_wr", bus.ram_wr, is_st);
        if (is_st) check("ram_dout", bus.ram_dout, (wdata >> (8 * (n - 1))) & 32'hFF);
      end
      if (bus.mem_busy !== 1'b1) busy_ok = 1'b0;
      if (own_mem ? bus.mem_done : bus.if_done) begin
        seen = 1'b1;
        got  = own_mem ? bus.mem_rdata : bus.if_data;
      end
      if (own_mem ? bus.if_done : bus.mem_done) stray = 1'b1;
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    check("done_seen", seen, 1'b1);
    check("latency", n, lat);
    check("data", got, exp);
    check("busy_during", busy_ok, 1'b1);
    check("other_done", stray, 1'b0);
    if (is_st) begin
      for (int k = 0; k < nb; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
      for (int k = 0; k < nb; k++) check("st_byte", ram_rd(addr + 32'(k)), ref_rd(addr + 32'(k)));
    end
    @(posedge clk); #1;
    check("done_pulse_1cyc", own_mem ? bus.mem_done : bus.if_done, 1'b0);
    check("idle_busy", bus.mem_busy, 1'b0);
    @(negedge clk);
  endtask

  // Both requesters at once; report who finishes first and when
  task automatic race(output logic first_mem, output int cyc, output logic [31:0] got);
    logic seen;
    bus.mem_req = 1'b1; bus.mem_req_type = 4'd3; bus.mem_req_addr = 32'h240;
    bus.if_req  = 1'b1; bus.if_addr = 32'h340;
    cyc = 0; seen = 1'b0; first_mem = 1'b0; got = 32'h0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (bus.mem_done || bus.if_done) begin
        seen = 1'b1; first_mem = bus.mem_done;
        got = bus.mem_done ? bus.mem_rdata : bus.if_data;
      end
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] got, got_m, got_i, a, d;
    logic [3:0]  typ;
    logic        own, stray, busy_bad, first_mem;
    int          t_m, t_i, n, cyc;

    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_req_addr = 32'h0;
    bus.mem_req_data = 32'h0; bus.mem_req_type = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_if_done", bus.if_done, 1'b0);
    check("rst_if_data", bus.if_data, 32'h0);
    check("rst_busy", bus.mem_busy, 1'b0);
    check("rst_mem_done", bus.mem_done, 1'b0);
    check("rst_rdata", bus.mem_rdata, 32'h0);
    check("rst_dout", bus.ram_dout, 8'h00);
    check("rst_ram_a", bus.ram_a, 32'h0);
    check("rst_ram_wr", bus.ram_wr, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Instruction fetch
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    issue(1'b0, 4'd0, 32'h100, 32'h0, got);
    check("if_word", got, 32'h0000_0513);

    // Byte / half loads with extension
    poke(32'h20, 8'h80);
    issue(1'b1, 4'd1, 32'h20, 32'h0, got);
    check("lb_sext", got, 32'hFFFF_FF80);
    issue(1'b1, 4'd5, 32'h20, 32'h0, got);
    check("lbu_zext", got, 32'h0000_0080);
    poke(32'h20, 8'h34); poke(32'h21, 8'h92);
    issue(1'b1, 4'd2, 32'h20, 32'h0, got);
    check("lh_sext", got, 32'hFFFF_9234);

    // Word store across the address wrap
    issue(1'b1, 4'd8, 32'hFFFF_FFFE, 32'hAABB_CCDD, got);
    check("sw_rdata", got, 32'h0);
    check("sw_b0", ram_rd(32'hFFFF_FFFE), 8'hDD);
    check("sw_b1", ram_rd(32'hFFFF_FFFF), 8'hCC);
    check("sw_b2", ram_rd(32'h0000_0000), 8'hBB);
    check("sw_b3", ram_rd(32'h0000_0001), 8'hAA);

    // Reset in the middle of a word store
    bus.mem_req = 1'b1; bus.mem_req_type = 4'd8;
    bus.mem_req_addr = 32'h400; bus.mem_req_data = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_wr_before", bus.ram_wr, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wr", bus.ram_wr, 1'b0);
    check("rst_mid_busy", bus.mem_busy, 1'b0);
    check("rst_mid_done", bus.mem_done, 1'b0);
    bus.mem_req = 1'b0;
    ref_mem[32'h400] = 8'h44;
    @(negedge clk); rst = 1'b0;
    stray = 1'b0; busy_bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.mem_done) stray = 1'b1;
      if (bus.mem_busy) busy_bad = 1'b1;
    end
    check("rst_mid_no_done", stray, 1'b0);
    check("rst_mid_idle", busy_bad, 1'b0);
    check("rst_mid_byte0", ram_rd(32'h400), 8'h44);
    check("rst_mid_byte1", ram_rd(32'h401), dflt(32'h401));
    @(negedge clk);

    // Simultaneous LW and IF: MEM first, then IF once MEM drops its request
    bus.mem_req = 1'b1; bus.mem_req_type = 4'd3; bus.mem_req_addr = 32'h200;
    bus.if_req  = 1'b1; bus.if_addr = 32'h300;
    t_m = 0; t_i = 0; n = 0; stray = 1'b0; got_m = 32'h0; got_i = 32'h0;
    while (t_i == 0 && n < 40) begin
      @(posedge clk); #1; n++;
      if (bus.mem_done) begin
        if (t_m == 0) t_m = n; else stray = 1'b1;
        got_m = bus.mem_rdata; bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        t_i = n; got_i = bus.if_data; bus.if_req = 1'b0;
      end
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    check("arb_mem_time", t_m, 6);
    check("arb_if_time", t_i, 13);
    check("arb_mem_data", got_m, ref_load(4'd3, 32'h200));
    check("arb_if_data", got_i, ref_load(4'd3, 32'h300));
    check("arb_mem_once", stray, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);

    // Repeated tie after IF was served last: MEM wins in both builds
    race(first_mem, cyc, got);
    check("race1_owner", first_mem, 1'b1);
    check("race1_time", cyc, 6);
    check("race1_data", got, ref_load(4'd3, 32'h240));

    // Tie right after MEM was served
    race(first_mem, cyc, got);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("race2_owner", first_mem, 1'b0);
    check("race2_data", got, ref_load(4'd3, 32'h340));
`else
    check("race2_owner", first_mem, 1'b1);
    check("race2_data", got, ref_load(4'd3, 32'h240));
`endif
    check("race2_time", cyc, 6);

    // Invalid MEM type alongside IF: IF is served, MEM never completes
    bus.mem_req = 1'b1; bus.mem_req_type = 4'd0; bus.mem_req_addr = 32'h20;
    bus.if_req  = 1'b1; bus.if_addr = 32'h100;
    t_i = 0; n = 0; stray = 1'b0; got = 32'h0;
    while (t_i == 0 && n < 20) begin
      @(posedge clk); #1; n++;
      if (bus.mem_done) stray = 1'b1;
      if (bus.if_done) begin t_i = n; got = bus.if_data; bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0;
    bus.mem_req_type = 4'd12;
    busy_bad = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.mem_done) stray = 1'b1;
      if (n > 0 && bus.mem_busy) busy_bad = 1'b1;
    end
    bus.mem_req = 1'b0;
    check("inv_if_time", t_i, 6);
    check("inv_if_data", got, 32'h0000_0513);
    check("inv_no_mem_done", stray, 1'b0);
    check("inv_no_grant", busy_bad, 1'b0);
    @(negedge clk);

    // Randomized single-requester traffic, including wrap-around addresses
    for (int i = 0; i < 40; i++) begin
      own = 1'($urandom_range(0, 1));
      typ = 4'($urandom_range(1, 8));
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = $urandom & 32'h0000_0FFF;
      d = $urandom;
      issue(own, typ, a, d, got);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Owns the single byte-wide RAM port and serves two requesters: instruction fetch (IF) and the MEM stage (loads/stores).
- Arbitrates between them, then sequences each 32-bit access as 1/2/4 single-byte RAM cycles.
- Assembles and sign/zero-extends read data and returns it with a one-cycle done pulse.
- mem_busy tells the MEM stage when a new request may be issued.

Parameters:
- ADDR_W, 32, width of all addresses and of ram_a.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  IF requests a 4-byte instruction read; held until if_done.
- if_addr  in  ADDR_W  IF fetch address.
- if_done  out  1  one-cycle pulse: if_data valid.
- if_data  out  32  fetched instruction, little-endian.
- mem_req  in  1  MEM stage request; held until mem_done.
- mem_req_addr  in  ADDR_W  byte address of the access.
- mem_req_data  in  32  store data; low bytes used.
- mem_req_type  in  4  1=LB 2=LH 3=LW 4=LHU 5=LBU 6=SB 7=SH 8=SW; 0 and 9-15 are invalid.
- mem_busy  out  1  high whenever the FSM is not IDLE.
- mem_done  out  1  one-cycle pulse: load data valid, or store complete.
- mem_rdata  out  32  extended load data; 0 for stores.
- ram_din  in  8  RAM read byte; valid the cycle after its address.
- ram_dout  out  8  RAM write byte.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  1 = write ram_dout to ram_a this cycle.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset is asynchronous, so it also aborts any transaction in flight (ram_wr drops to 0 immediately, no done pulse).
- States: IDLE, RD, RD_LAST, WR, DONE. All outputs are registered.
- IDLE:
  - Samples the requests and latches addr, data, type, owner and N, where N = 1 (B), 2 (H) or 4 (W/IF).
  - A valid-type mem_req beats if_req (fixed priority, see optional feature).
  - An invalid type is ignored (no grant, no done); IF may be granted in that cycle instead.
  - Grant a read → RD with cnt=0. Grant a store → WR with cnt=0.
- Read granted in cycle T:
  - Cycles T+1..T+N drive ram_a=addr+k, ram_wr=0.
  - Byte k is captured from ram_din at T+2+k into bits [8k+7:8k].
  - After the last address (cnt==N-1), RD goes to RD_LAST. RD_LAST captures the final byte, then goes to DONE.
- Store granted in cycle T:
  - Cycles T+1..T+N drive ram_a=addr+k, ram_dout=data[8k+7:8k], ram_wr=1.
  - After byte N-1, WR goes to DONE.
- DONE: lasts one cycle.
  - Pulses if_done or mem_done according to the owner, with data valid.
  - ram_wr=0. Returns to IDLE.
- Latency, grant cycle T to done pulse: IF/LW = T+6, LH = T+4, LB = T+3, SW = T+5, SH = T+3, SB = T+2.
- Next grant is no earlier than the cycle after DONE. Requesters deassert or replace their request at the clock edge where done is seen.
- Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend. IF data is the raw 4 bytes.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W (0xFFFFFFFF+1 → 0x00000000).
- Latched copies are used throughout the transaction. Input changes or a dropped request mid-transaction are ignored, and the transaction completes.
- ram_a, ram_dout hold their last value when idle; only ram_wr is the significant strobe.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN.
- Defined: one last_owner flop, reset to IF.
  - When both requests are valid in IDLE, the requester that was not last granted wins.
  - A single requester is always granted.
- Undefined: fixed MEM-over-IF priority, no last_owner flop.

Test Plan:
- Reset mid-SW (rst asserted at T+2) → ram_wr=0 immediately, no mem_done; after reset release the FSM is IDLE and mem_busy=0.
- IF fetch addr 0x100, RAM bytes 13 05 00 00 → if_done at T+6 with if_data=0x00000513; ram_a steps 0x100..0x103; mem_busy high T+1..T+6.
- LB addr 0x20 with byte 0x80 → mem_rdata=0xFFFFFF80. LBU at the same addr → 0x00000080. LH at 0x20 with bytes 0x34,0x92 → 0xFFFF9234.
- SW addr 0xFFFFFFFE data 0xAABBCCDD → writes DD@0xFFFFFFFE, CC@0xFFFFFFFF, BB@0x0, AA@0x1; mem_done at T+5; mem_rdata=0.
- if_req and mem_req (LW) asserted in the same cycle, both held:
  - Default: MEM served first, then IF.
  - With MEM_ARB_ROUND_ROBIN_EN: MEM first, IF second, and a repeated simultaneous request next goes to MEM.
- mem_req_type=0 with if_req → IF granted, mem_done never pulses.
